// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the writeback slot scheduler.
// FU ids, default latencies, slot entry layout and the latency lookup.
package wb_sched_pkg;

    localparam logic [2:0] FU_NONE = 3'd0;
    localparam logic [2:0] FU_ALU  = 3'd1;
    localparam logic [2:0] FU_MEM  = 3'd2;
    localparam logic [2:0] FU_MUL  = 3'd3;
    localparam logic [2:0] FU_DIV  = 3'd4;
    localparam logic [2:0] FU_JUMP = 3'd5;

    localparam int NUM_FU = 6;

    localparam int SLOT_DEPTH_DEF = 32;
    localparam int ALU_LAT_DEF    = 1;
    localparam int MEM_LAT_DEF    = 2;
    localparam int MUL_LAT_DEF    = 7;
    localparam int DIV_LAT_DEF    = 24;
    localparam int JUMP_LAT_DEF   = 2;

    typedef struct packed {
        logic [2:0] fu;
        logic [4:0] rd;
        logic       wr;
    } slot_entry_t;

    localparam slot_entry_t SLOT_EMPTY = '0;

    // Latency of a (normalised) FU id; 0 for FU_NONE.
    function automatic int unsigned fu_lat(
        input logic [2:0]  fu,
        input int unsigned alu_lat,
        input int unsigned mem_lat,
        input int unsigned mul_lat,
        input int unsigned div_lat,
        input int unsigned jump_lat
    );
        int unsigned lat;
        lat = 0;
        case (fu)
            FU_ALU:  lat = alu_lat;
            FU_MEM:  lat = mem_lat;
            FU_MUL:  lat = mul_lat;
            FU_DIV:  lat = div_lat;
            FU_JUMP: lat = jump_lat;
            default: lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/wb_slot_table.sv
// Shifting writeback slot table: one indexed write port, slot[0] read
// port and a per-slot occupancy vector for booking lookups.
module wb_slot_table
    import wb_sched_pkg::*;
#(
    parameter int DEPTH = SLOT_DEPTH_DEF,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  slot_entry_t       wr_entry_i,
    output slot_entry_t       head_o,
    output logic [DEPTH-1:0]  occ_o
);

    slot_entry_t slot_q [DEPTH];
    slot_entry_t slot_d [DEPTH];

    // The booking write lands on the post-shift position.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        slot_d[DEPTH-1] = SLOT_EMPTY;
        if (wr_en_i) begin
            slot_d[wr_idx_i] = wr_entry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occ_o[i] = (slot_q[i].fu != FU_NONE);
        end
    end

    assign head_o = slot_q[0];

endmodule

// File: rtl/wb_slot_scheduler.sv
// Issue gate and writeback-port scheduler for the fixed-latency FUs:
// hazard checks, slot booking, busy/pending tracking, registered wb select.
module wb_slot_scheduler
    import wb_sched_pkg::*;
#(
    parameter int SLOT_DEPTH = SLOT_DEPTH_DEF,
    parameter int ALU_LAT    = ALU_LAT_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int JUMP_LAT   = JUMP_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_kill,
    input  logic [2:0]  issue_fu,
    input  logic        issue_wr,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    output logic        issue_ready,
    output logic        issue_fire,
    output logic        hz_struct,
    output logic        hz_slot,
    output logic        hz_raw,
    output logic        hz_waw,
    output logic [5:0]  fu_busy,
    output logic [31:0] pending_rd,
    output logic        wb_valid,
    output logic [2:0]  wb_fu,
    output logic [4:0]  wb_rd
);

    localparam int IW = $clog2(SLOT_DEPTH);

    function automatic bit lat_ok(input int lat);
        return (lat >= 1) && (lat <= SLOT_DEPTH - 1);
    endfunction

    if (!(lat_ok(ALU_LAT) && lat_ok(MEM_LAT) && lat_ok(MUL_LAT) &&
          lat_ok(DIV_LAT) && lat_ok(JUMP_LAT))) begin : g_bad_lat
        $error("wb_slot_scheduler: FU latency outside 1..SLOT_DEPTH-1");
    end

    logic [2:0]         fu_n;
    logic               has_fu;
    logic               wr_eff;
    int unsigned        lat;
    logic [IW-1:0]      lat_idx;
    logic [IW-1:0]      wr_idx;
    slot_entry_t        new_entry;
    slot_entry_t        head;
    logic [SLOT_DEPTH-1:0] occ;

    logic [NUM_FU-1:0]  busy_q, busy_d;
    logic [31:0]        pend_q, pend_d;
    logic               wbv_q, wbv_d;
    logic [2:0]         wbf_q, wbf_d;
    logic [4:0]         wbr_q, wbr_d;

    always_comb begin
        fu_n    = (issue_fu > FU_JUMP) ? FU_NONE : issue_fu;
        has_fu  = (fu_n != FU_NONE);
        wr_eff  = issue_wr & (issue_rd != 5'd0);
        lat     = fu_lat(fu_n, ALU_LAT, MEM_LAT, MUL_LAT,
                         DIV_LAT, JUMP_LAT);
        lat_idx = IW'(lat);
        wr_idx  = has_fu ? IW'(lat - 1) : '0;
        new_entry = '{fu: fu_n, rd: issue_rd, wr: wr_eff};
    end

    // An FU whose entry sits in slot[0] frees up at this edge.
    always_comb begin
        hz_struct = has_fu & busy_q[fu_n] & (head.fu != fu_n);
        hz_slot   = has_fu & occ[lat_idx];
        hz_raw    = has_fu &
                    (((issue_rs1 != 5'd0) & pend_q[issue_rs1]) |
                     ((issue_rs2 != 5'd0) & pend_q[issue_rs2]));
        hz_waw    = has_fu & wr_eff & pend_q[issue_rd];
        issue_ready = ~(hz_struct | hz_slot | hz_raw | hz_waw);
        issue_fire  = issue_valid & ~issue_kill & issue_ready & has_fu;
    end

    wb_slot_table #(
        .DEPTH (SLOT_DEPTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (issue_fire),
        .wr_idx_i   (wr_idx),
        .wr_entry_i (new_entry),
        .head_o     (head),
        .occ_o      (occ)
    );

    // Clears are applied before sets so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (head.fu != FU_NONE) begin
            busy_d[head.fu] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[fu_n] = 1'b1;
        end
        busy_d[0] = 1'b0;

        pend_d = pend_q;
        if (wbv_q) begin
            pend_d[wbr_q] = 1'b0;
        end
        if (issue_fire && wr_eff) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;

        wbv_d = (head.fu != FU_NONE) & head.wr;
        wbf_d = head.fu;
        wbr_d = head.rd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            pend_q <= '0;
            wbv_q  <= 1'b0;
            wbf_q  <= FU_NONE;
            wbr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            wbv_q  <= wbv_d;
            wbf_q  <= wbf_d;
            wbr_q  <= wbr_d;
        end
    end

    assign fu_busy    = busy_q;
    assign pending_rd = pend_q;
    assign wb_valid   = wbv_q;
    assign wb_fu      = wbf_q;
    assign wb_rd      = wbr_q;

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Bench for wb_slot_scheduler: directed scenarios with literal
// expectations plus randomized traffic against an op-list model.
module tb_wb_slot_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_kill = 1'b0;
    logic [2:0]  issue_fu = 3'd0;
    logic        issue_wr = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic [4:0]  issue_rs1 = 5'd0;
    logic [4:0]  issue_rs2 = 5'd0;
    logic        issue_ready, issue_fire;
    logic        hz_struct, hz_slot, hz_raw, hz_waw;
    logic [5:0]  fu_busy;
    logic [31:0] pending_rd;
    logic        wb_valid;
    logic [2:0]  wb_fu;
    logic [4:0]  wb_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_slot_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_kill  (issue_kill),
        .issue_fu    (issue_fu),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .issue_fire  (issue_fire),
        .hz_struct   (hz_struct),
        .hz_slot     (hz_slot),
        .hz_raw      (hz_raw),
        .hz_waw      (hz_waw),
        .fu_busy     (fu_busy),
        .pending_rd  (pending_rd),
        .wb_valid    (wb_valid),
        .wb_fu       (wb_fu),
        .wb_rd       (wb_rd)
    );

    // Model: list of in-flight ops with the edge index they issued on.
    typedef struct {
        int fu;
        int rd;
        bit wr;
        int e;
        int lat;
    } op_t;

    typedef struct {
        logic        ready, fire, hs, hsl, hr, hw;
        logic [5:0]  busy;
        logic [31:0] pend;
        logic        wbv;
        logic [2:0]  wbf;
        logic [4:0]  wbr;
    } exp_t;

    op_t ops[$];
    int  cyc = 0;
    bit  synced = 0;

    function automatic int lat_of(int f);
        case (f)
            1: return 1;
            2: return 2;
            3: return 7;
            4: return 24;
            5: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     nm, act, req, cyc);
        end
    endfunction

    // State "after edge cyc", evaluated with the current ID inputs.
    function automatic exp_t model_eval();
        exp_t x;
        int f, l, t;
        bit wrp;
        x = '{default: '0};
        t = cyc;
        f = (int'(issue_fu) > 5) ? 0 : int'(issue_fu);
        l = lat_of(f);
        wrp = issue_wr && (issue_rd != 0);
        foreach (ops[i]) begin
            if (t >= ops[i].e && t <= ops[i].e + ops[i].lat - 1)
                x.busy[ops[i].fu] = 1'b1;
            if (f != 0 && ops[i].fu == f && t >= ops[i].e &&
                t < ops[i].e + ops[i].lat - 1)
                x.hs = 1'b1;
            if (f != 0 && ops[i].e + ops[i].lat == t + 1 + l)
                x.hsl = 1'b1;
            if (ops[i].wr && t >= ops[i].e && t <= ops[i].e + ops[i].lat)
                x.pend[ops[i].rd] = 1'b1;
            if (ops[i].e + ops[i].lat == t) begin
                x.wbv = ops[i].wr;
                x.wbf = 3'(ops[i].fu);
                x.wbr = 5'(ops[i].rd);
            end
        end
        if (f != 0) begin
            x.hr = (issue_rs1 != 0 && x.pend[issue_rs1]) ||
                   (issue_rs2 != 0 && x.pend[issue_rs2]);
            x.hw = wrp && x.pend[issue_rd];
        end
        x.ready = !(x.hs || x.hsl || x.hr || x.hw);
        x.fire = issue_valid && !issue_kill && x.ready && f != 0;
        return x;
    endfunction

    always @(posedge clk) begin : mdl
        exp_t x;
        op_t  o;
        x = model_eval();
        if (!rst) begin
            ops.delete();
            synced = 1;
        end else if (x.fire) begin
            o.fu  = int'(issue_fu);
            o.rd  = int'(issue_rd);
            o.wr  = issue_wr && (issue_rd != 0);
            o.e   = cyc + 1;
            o.lat = lat_of(o.fu);
            ops.push_back(o);
        end
        cyc++;
        for (int i = ops.size() - 1; i >= 0; i--) begin
            if (ops[i].e + ops[i].lat < cyc) ops.delete(i);
        end
    end

    always @(negedge clk) begin : cmp
        exp_t x;
        if (synced) begin
            x = model_eval();
            chk("ready", 32'(issue_ready), 32'(x.ready));
            chk("fire", 32'(issue_fire), 32'(x.fire));
            chk("hz_struct", 32'(hz_struct), 32'(x.hs));
            chk("hz_slot", 32'(hz_slot), 32'(x.hsl));
            chk("hz_raw", 32'(hz_raw), 32'(x.hr));
            chk("hz_waw", 32'(hz_waw), 32'(x.hw));
            chk("fu_busy", 32'(fu_busy), 32'(x.busy));
            chk("pending_rd", pending_rd, x.pend);
            chk("wb_valid", 32'(wb_valid), 32'(x.wbv));
            chk("wb_fu", 32'(wb_fu), 32'(x.wbf));
            chk("wb_rd", 32'(wb_rd), 32'(x.wbr));
        end
    end

    task automatic drive(bit v, bit k, int f, bit w, int rd,
                         int r1, int r2);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_kill  = k;
        issue_fu    = 3'(f);
        issue_wr    = w;
        issue_rd    = 5'(rd);
        issue_rs1   = 5'(r1);
        issue_rs2   = 5'(r2);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int stalls;
        int wbcnt;
        bit fired;

        repeat (3) idle();
        at_neg();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_busy", 32'(fu_busy), 0);
        chk("rst_pending", pending_rd, 0);
        chk("rst_ready", 32'(issue_ready), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) idle();
        at_neg();
        chk("idle_ready", 32'(issue_ready), 1);
        chk("idle_wb", 32'(wb_valid), 0);

        // ALU rd=x5
        drive(1, 0, 1, 1, 5, 0, 0);
        at_neg();
        chk("alu_fire", 32'(issue_fire), 1);
        idle();
        at_neg();
        chk("alu_wb_early", 32'(wb_valid), 0);
        chk("alu_pend_set", 32'(pending_rd[5]), 1);
        idle();
        at_neg();
        chk("alu_wb_valid", 32'(wb_valid), 1);
        chk("alu_wb_fu", 32'(wb_fu), 1);
        chk("alu_wb_rd", 32'(wb_rd), 5);
        idle();
        at_neg();
        chk("alu_wb_late", 32'(wb_valid), 0);
        chk("alu_pend_clr", 32'(pending_rd[5]), 0);

        // MEM rd=x4 then ALU rd=x6 colliding on the wb slot
        drive(1, 0, 2, 1, 4, 0, 0);
        at_neg();
        chk("mem_fire", 32'(issue_fire), 1);
        drive(1, 0, 1, 1, 6, 0, 0);
        at_neg();
        chk("slot_hz", 32'(hz_slot), 1);
        chk("slot_ready", 32'(issue_ready), 0);
        drive(1, 0, 1, 1, 6, 0, 0);
        at_neg();
        chk("slot_reissue", 32'(issue_fire), 1);
        idle();
        at_neg();
        chk("slot_wb1_fu", 32'(wb_fu), 2);
        chk("slot_wb1_rd", 32'(wb_rd), 4);
        idle();
        at_neg();
        chk("slot_wb2_fu", 32'(wb_fu), 1);
        chk("slot_wb2_rd", 32'(wb_rd), 6);
        repeat (4) idle();

        // MUL rd=x3 then dependent ALU
        drive(1, 0, 3, 1, 3, 0, 0);
        at_neg();
        chk("mul_fire", 32'(issue_fire), 1);
        stalls = 0;
        fired = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            drive(1, 0, 1, 1, 8, 3, 0);
            at_neg();
            if (i == 0) chk("raw_flag", 32'(hz_raw), 1);
            if (issue_fire) fired = 1;
            else stalls++;
        end
        chk("raw_stalls", 32'(stalls), 8);
        repeat (4) idle();

        // DIV back to back
        drive(1, 0, 4, 1, 7, 0, 0);
        at_neg();
        chk("div_fire", 32'(issue_fire), 1);
        stalls = 0;
        fired = 0;
        for (int i = 0; i < 40 && !fired; i++) begin
            drive(1, 0, 4, 1, 9, 0, 0);
            at_neg();
            if (issue_fire) begin
                fired = 1;
                chk("div_busy_at_reissue", 32'(fu_busy[4]), 1);
            end else if (hz_struct) begin
                stalls++;
            end
        end
        chk("div_struct_stalls", 32'(stalls), 23);
        repeat (30) idle();

        // store (wr=0) and rd=x0
        drive(1, 0, 2, 0, 10, 0, 0);
        idle();
        at_neg();
        chk("st_pend", pending_rd, 0);
        idle();
        idle();
        at_neg();
        chk("st_wb_valid", 32'(wb_valid), 0);
        chk("st_wb_fu", 32'(wb_fu), 2);
        drive(1, 0, 1, 1, 0, 0, 0);
        idle();
        at_neg();
        chk("x0_pend", pending_rd, 0);
        idle();
        at_neg();
        chk("x0_wb_valid", 32'(wb_valid), 0);
        chk("x0_wb_fu", 32'(wb_fu), 1);

        // killed MUL
        drive(1, 1, 3, 1, 12, 0, 0);
        at_neg();
        chk("kill_fire", 32'(issue_fire), 0);
        idle();
        at_neg();
        chk("kill_busy", 32'(fu_busy[3]), 0);
        repeat (4) idle();

        // reset in the middle of a DIV
        drive(1, 0, 4, 1, 11, 0, 0);
        repeat (5) idle();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        wbcnt = 0;
        for (int i = 0; i < 30; i++) begin
            at_neg();
            if (wb_valid) wbcnt++;
        end
        chk("rst_div_wb", 32'(wbcnt), 0);
        chk("rst_div_busy", 32'(fu_busy), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst         = ($urandom_range(0, 299) != 0);
            issue_valid = ($urandom_range(0, 9) < 8);
            issue_kill  = ($urandom_range(0, 9) == 0);
            issue_fu    = 3'($urandom_range(0, 7));
            issue_wr    = ($urandom_range(0, 9) < 8);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (30) idle();
        at_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
- Schedules the single shared writeback port across the fixed-latency functional units: ALU, MEM, MUL, DIV and JUMP.
- Sits between ID and the FUs. Decides whether the ID instruction may issue: structural, writeback-slot, RAW and WAW checks.
- Books the instruction's writeback cycle in a shifting slot table.
- Drives the registered writeback select (wb_valid/wb_fu/wb_rd) consumed by the WB mux and register file.

Parameters:
- SLOT_DEPTH, 32, number of slot-table entries; every latency must be in 1..SLOT_DEPTH-1.
- ALU_LAT, 1, ALU issue-to-writeback cycles.
- MEM_LAT, 2, MEM issue-to-writeback cycles.
- MUL_LAT, 7, MUL issue-to-writeback cycles.
- DIV_LAT, 24, DIV issue-to-writeback cycles.
- JUMP_LAT, 2, JUMP issue-to-writeback cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low
- issue_valid  in  1  ID holds a valid instruction
- issue_kill  in  1  ID flushed this cycle; the request is ignored
- issue_fu  in  3  FU id: 0 none, 1 ALU, 2 MEM, 3 MUL, 4 DIV, 5 JUMP; 6-7 treated as 0
- issue_wr  in  1  instruction writes rd
- issue_rd  in  5  destination register
- issue_rs1  in  5  source 1 (0 means unused)
- issue_rs2  in  5  source 2 (0 means unused)
- issue_ready  out  1  combinational; instruction may issue this cycle
- issue_fire  out  1  combinational; issue_valid & ~issue_kill & issue_ready & (fu 1..5)
- hz_struct, hz_slot, hz_raw, hz_waw  out  1 each  combinational hazard causes
- fu_busy  out  6  bit n: FU n has an op in flight; bit 0 always 0
- pending_rd  out  32  bit r: in-flight write to xr; bit 0 always 0
- wb_valid  out  1  registered; writeback this cycle
- wb_fu  out  3  registered; FU selected for writeback
- wb_rd  out  5  registered; register-file write address

Behaviour:
- Reset (rst=0 at a clock edge) clears all slots, fu_busy, pending_rd and wb_* to 0. In-flight ops are dropped and never write back; this also applies mid-operation.
- Slot entry: {fu[2:0], rd[4:0], wr}. Empty when fu=0. Every cycle the table shifts: slot[i] <= slot[i+1], and slot[SLOT_DEPTH-1] <= empty.
- Each edge, the wb register is loaded: wb_valid <= (slot[0].fu!=0) & slot[0].wr; wb_fu <= slot[0].fu; wb_rd <= slot[0].rd.
- On issue_fire, slot[LAT(fu)-1] <= {fu, rd, wr'}, where wr' = issue_wr & (issue_rd!=0). The write overrides the shift at that index. wb_valid therefore appears exactly LAT cycles after the issuing edge.
- hz_slot = (pre-shift) slot[LAT(fu)] non-empty.
- hz_struct = fu_busy[fu] & ~(slot[0].fu==fu). An FU retiring this edge may be reissued in the same cycle.
- hz_raw = rsN!=0 & pending_rd[rsN], for N = 1, 2.
- hz_waw = wr' & pending_rd[issue_rd].
- issue_ready = ~(hz_struct|hz_slot|hz_raw|hz_waw) when fu is 1..5; issue_ready = 1 when fu is 0.
  - When fu is 0, the hazard outputs are forced 0 and nothing is recorded.
- fu_busy[fu] sets on issue_fire. It clears at the edge where that FU's entry leaves slot[0]; a simultaneous set wins.
- pending_rd[rd] sets on issue_fire when wr'=1. It clears at the edge where that entry leaves the wb register, i.e. after the register-file write cycle.
  - If the same rd is set and cleared at one edge, set wins; WAW makes this unreachable, but it is required anyway.
- issue_kill=1 or issue_valid=0: no recording; the shift and retire still proceed.
- Writeback slots never collide because of hz_slot. Latency parameters out of range are an elaboration error.

Decomposition:
- Shared package wb_sched_pkg:
  - FU id constants FU_NONE..FU_JUMP.
  - Default latency constants.
  - slot_entry_t typedef {fu, rd, wr}.
  - Function fu_lat(fu) returning the latency.
- One sub-module, wb_slot_table: the shifting slot array with a single indexed write port and a slot[0] read port.
- Hazard logic, busy/pending tracking and the wb register stay in wb_slot_scheduler.

Test Plan:
- Reset, idle 40 cycles: all outputs 0 and issue_ready=1 with fu=0; rst held low mid-DIV at cycle 5 -> no writeback ever appears.
- ALU add, rd=x5, issued at edge 0: wb_valid=1, wb_fu=1, wb_rd=5 in the cycle after edge 1 only; pending_rd[5] clears one edge later.
- MUL rd=x3 at edge 0, then ALU reading rs1=x3: hz_raw=1 and issue_ready=0 until pending_rd[3] clears; the ALU issues on the first ready cycle.
- MEM rd=x4 at edge 0, then ALU rd=x6 at edge 1: both target the same wb cycle -> hz_slot=1 at edge 1, ALU issues at edge 2, wb order is MEM then ALU on consecutive cycles.
- DIV rd=x7, then a second DIV next cycle -> hz_struct=1 for 23 cycles; reissue is accepted in the cycle where the first DIV's entry sits in slot[0].
- Store (wr=0) and an instruction with rd=x0 -> pending_rd stays 0 and wb_valid stays 0 at their writeback cycle; issue_kill=1 with a valid MUL -> fu_busy[3] stays 0.
